spi_slave_reg_arb: RTL and testbench

SPI_SLAVE_REG_ARB -- requirements
Module: spi_slave_reg_arb

---
 rtl/spi_slave_reg_arb.sv | 116 +++++++++++
 tb/tb_spi_slave_reg_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_reg_arb.sv
// Register bank shared between an spi_slave byte interface and a local port.
// SPI writes cross into clk through a 3-flop strobe synchronizer; bank access is round-robin arbitrated.
module spi_slave_reg_arb #(
    parameter int n = 8,
    parameter int k = 2,
    parameter int a = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         strobe,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] out,
    output logic [n-1:0] in,
    output logic         zo,
    input  logic         lreq,
    input  logic         lwe,
    input  logic [k-1:0] laddr,
    input  logic [n-1:0] ldin,
    output logic         lgnt,
    output logic [n-1:0] ldout,
    output logic         ovf
);

    localparam int depth = 2 ** k;
    localparam int sel_w = n - 1 - k;
    localparam logic [sel_w-1:0] bank_id = sel_w'(a >> k);

    logic [n-1:0] bank [depth];

    logic         s1, s2, s3;
    logic         spi_pend;
    logic [k-1:0] spi_idx_q;
    logic [n-1:0] spi_dat_q;
    logic         last;

    logic         addr_hit;
    logic         sel;
    logic         detect;
    logic         spi_wr_det;
    logic         lreq_eff;
    logic         grant_spi;
    logic         grant_loc;

    assign addr_hit = (addr[n-2:k] == bank_id);
    assign sel      = strobe && addr_hit;

    // Read path is purely combinational so the byte is ready before spi_slave shifts it out.
    always_comb begin
        in = '0;
        zo = 1'b1;
        if (sel) begin
            in = bank[addr[k-1:0]];
            zo = 1'b0;
        end
    end

    assign detect     = s2 && !s3;
    assign spi_wr_det = detect && addr_hit && addr[n-1];

    // Local handshake: lreq is held until lgnt; lgnt is a one-cycle pulse in the
    // cycle after the access, and a request seen while lgnt=1 is the one just served.
    assign lreq_eff  = lreq && !lgnt;
    assign grant_spi = spi_pend && (!lreq_eff || last);
    assign grant_loc = lreq_eff && (!spi_pend || !last);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                bank[i] <= '0;
            end
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            spi_pend  <= 1'b0;
            spi_idx_q <= '0;
            spi_dat_q <= '0;
            last      <= 1'b1;
            lgnt      <= 1'b0;
            ldout     <= '0;
            ovf       <= 1'b0;
        end else begin
            s1   <= strobe;
            s2   <= s1;
            s3   <= s2;
            lgnt <= grant_loc;

            if (grant_spi) begin
                bank[spi_idx_q] <= spi_dat_q;
                last            <= 1'b0;
            end

            if (grant_loc) begin
                last <= 1'b1;
                if (lwe) begin
                    bank[laddr] <= ldin;
                end else begin
                    ldout <= bank[laddr];
                end
            end

            // A capture slot freed by this cycle's grant can take a new write without overrun.
            if (spi_wr_det) begin
                if (!spi_pend || grant_spi) begin
                    spi_idx_q <= addr[k-1:0];
                    spi_dat_q <= out;
                    spi_pend  <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (grant_spi) begin
                spi_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_reg_arb.sv
// Randomized bench for spi_slave_reg_arb against a transaction-level model of the bank and arbiter.
module tb_spi_slave_reg_arb;

    localparam int N = 8;
    localparam int K = 2;

    logic         clk;
    logic         rst;
    logic         strobe;
    logic [N-1:0] addr;
    logic [N-1:0] out;
    logic [N-1:0] in;
    logic         zo;
    logic         lreq;
    logic         lwe;
    logic [K-1:0] laddr;
    logic [N-1:0] ldin;
    logic         lgnt;
    logic [N-1:0] ldout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking_on = 0;

    spi_slave_reg_arb #(.n(N), .k(K), .a(0)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .out(out),
        .in(in), .zo(zo), .lreq(lreq), .lwe(lwe), .laddr(laddr), .ldin(ldin),
        .lgnt(lgnt), .ldout(ldout), .ovf(ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_bank [4];
    bit           m_pend;
    logic [K-1:0] m_idx;
    logic [N-1:0] m_dat;
    bit           m_local_last;
    bit           m_lgnt;
    logic [N-1:0] m_ldout;
    bit           m_ovf;
    bit           strobe_hist[$];
    logic [N-1:0] exp_q[$];

    function automatic bit is_mine(input logic [N-1:0] ad);
        return ad[N-2:K] == '0;
    endfunction

    task automatic model_reset();
        foreach (m_bank[i]) m_bank[i] = '0;
        m_pend = 0; m_idx = '0; m_dat = '0;
        m_local_last = 1; m_lgnt = 0; m_ldout = '0; m_ovf = 0;
        strobe_hist = '{0, 0, 0};
        exp_q.delete();
    endtask

    initial model_reset();

    always @(posedge clk) begin
        bit rose, wr_req, loc_wants, spi_turn, loc_turn;
        if (rst) begin
            model_reset();
        end else begin
            // strobe seen high two samples ago and low the sample before that
            rose = strobe_hist[1] && !strobe_hist[0];
            void'(strobe_hist.pop_front());
            strobe_hist.push_back(strobe);
            wr_req    = rose && is_mine(addr) && addr[N-1];
            loc_wants = lreq && !m_lgnt;
            if (m_pend && loc_wants) spi_turn = m_local_last;
            else                     spi_turn = m_pend;
            loc_turn = loc_wants && !spi_turn;
            if (spi_turn) begin
                m_bank[m_idx] = m_dat;
                m_pend = 0;
                m_local_last = 0;
            end
            m_lgnt = loc_turn;
            if (loc_turn) begin
                m_local_last = 1;
                if (lwe) m_bank[laddr] = ldin;
                else     m_ldout = m_bank[laddr];
                exp_q.push_back(m_ldout);
            end
            if (wr_req) begin
                if (m_pend) m_ovf = 1;
                else begin
                    m_pend = 1; m_idx = addr[K-1:0]; m_dat = out;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        bit m_sel;
        if (checking_on) begin
            m_sel = strobe && is_mine(addr);
            check("in",   in,   m_sel ? m_bank[addr[K-1:0]] : '0);
            check("zo",   zo,   !m_sel);
            check("lgnt", lgnt, m_lgnt);
            check("ovf",  ovf,  m_ovf);
            if (lgnt) begin
                if (exp_q.size() > 0) check("ldout", ldout, exp_q.pop_front());
                else                  check("lgnt_extra", lgnt, 0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [N-1:0] ad, input logic [N-1:0] d, input int hi, input int lo);
        addr = ad; out = d; strobe = 1'b1;
        repeat (hi) tick();
        strobe = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic local_req(input logic we, input logic [K-1:0] idx, input logic [N-1:0] d);
        int waited;
        lreq = 1'b1; lwe = we; laddr = idx; ldin = d;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!lgnt && waited < 3);
        check("lgnt_latency", lgnt, 1'b1);
        lreq = 1'b0;
    endtask

    task automatic spi_read_check(input logic [K-1:0] idx, input logic [N-1:0] exp);
        addr = {1'b0, {(N-1-K){1'b0}}, idx}; strobe = 1'b1;
        #1;
        check("rd_in", in, exp);
        check("rd_zo", zo, 1'b0);
        tick();
        strobe = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; strobe = 1'b0; addr = '0; out = '0;
        lreq = 1'b0; lwe = 1'b0; laddr = '0; ldin = '0;
        do_reset();
        checking_on = 1;
        check("rst_lgnt", lgnt, 1'b0);
        check("rst_ldout", ldout, '0);
        check("rst_ovf", ovf, 1'b0);

        // SPI write, visible within 4 clocks of strobe rise while still selected
        addr = 8'h81; out = 8'h5A; strobe = 1'b1;
        repeat (4) tick();
        check("wr_latency", in, 8'h5A);
        strobe = 1'b0;
        repeat (3) tick();
        spi_read_check(2'd1, 8'h5A);

        // non-selected address: no drive, no write
        addr = 8'h85; out = 8'h77; strobe = 1'b1;
        #1;
        check("nsel_in", in, '0);
        check("nsel_zo", zo, 1'b1);
        repeat (3) tick();
        strobe = 1'b0;
        repeat (3) tick();
        spi_read_check(2'd1, 8'h5A);

        // contention right after reset: SPI first, then local
        do_reset();
        fork
            spi_xfer(8'h82, 8'h11, 4, 2);
            begin repeat (3) tick(); local_req(1'b1, 2'd2, 8'h33); end
        join
        repeat (3) tick();
        spi_read_check(2'd2, 8'h33);

        // back-to-back conflicts with held local traffic
        fork
            for (int i = 0; i < 8; i++)
                spi_xfer({1'b1, 5'b0, 2'(i)}, 8'($urandom), 2, 1);
            for (int i = 0; i < 10; i++)
                local_req(1'($urandom), 2'(i), 8'($urandom));
        join
        repeat (4) tick();

        // local read of an index racing an SPI write to it
        fork
            spi_xfer(8'h83, 8'hC3, 3, 2);
            begin repeat (3) tick(); local_req(1'b0, 2'd3, '0); local_req(1'b0, 2'd3, '0); end
        join
        repeat (4) tick();

        // reset while an SPI write is pending
        fork
            spi_xfer(8'h83, 8'hEE, 3, 3);
            begin repeat (3) tick(); rst = 1'b1; tick(); rst = 1'b0; end
        join
        check("mid_rst_ovf", ovf, 1'b0);
        repeat (4) tick();
        spi_read_check(2'd3, 8'h00);

        // randomized mix of SPI and local traffic
        for (int it = 0; it < 60; it++) begin
            fork
                for (int j = 0; j < 3; j++) begin
                    logic [N-1:0] ad;
                    ad = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) ad[N-2:K] = '0;
                    spi_xfer(ad, 8'($urandom), $urandom_range(2, 4), $urandom_range(1, 3));
                end
                for (int j = 0; j < 3; j++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    local_req(1'($urandom), 2'($urandom), 8'($urandom));
                end
            join
        end
        repeat (6) tick();

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
